// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HOLD,
        RELEASE,
        GAP
    } state_t;

    // Feedback mask for x^8+x^6+x^5+x^4+1, bit 7 is the oldest stage
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Returns {row_onehot, col_onehot}; row0 is the top row, col0 the left column
    function automatic logic [7:0] key_to_rowcol(input logic [3:0] key);
        logic [7:0] rc;
        case (key)
            4'h1:    rc = {4'b0001, 4'b0001};
            4'h2:    rc = {4'b0001, 4'b0010};
            4'h3:    rc = {4'b0001, 4'b0100};
            4'hA:    rc = {4'b0001, 4'b1000};
            4'h4:    rc = {4'b0010, 4'b0001};
            4'h5:    rc = {4'b0010, 4'b0010};
            4'h6:    rc = {4'b0010, 4'b0100};
            4'hB:    rc = {4'b0010, 4'b1000};
            4'h7:    rc = {4'b0100, 4'b0001};
            4'h8:    rc = {4'b0100, 4'b0010};
            4'h9:    rc = {4'b0100, 4'b0100};
            4'hC:    rc = {4'b0100, 4'b1000};
            4'hE:    rc = {4'b1000, 4'b0001};
            4'h0:    rc = {4'b1000, 4'b0010};
            4'hF:    rc = {4'b1000, 4'b0100};
            default: rc = {4'b1000, 4'b1000};
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Key-press request channel: valid/ready handshake carrying key code and hold time.
interface keypad_if #(
    parameter int unsigned CNT_W = 24
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_key;
    logic [CNT_W-1:0] req_hold;

    modport master (output req_valid, output req_key, output req_hold, input req_ready);
    modport slave  (input req_valid, input req_key, input req_hold, output req_ready);
endinterface

// File: rtl/chatter_lfsr.sv
// 8-bit Fibonacci LFSR producing contact chatter while a key edge settles.
module chatter_lfsr
    import keypad_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic chatter
);

    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign chatter = lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad: closes the requested key for a hold time, then enforces a gap.
// Optional contact bounce on press/release edges when KEYPAD_BOUNCE_EN is defined.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned GAP_CYCLES    = 1000,
    parameter int unsigned BOUNCE_CYCLES = 200,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    keypad_if.slave    req,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 || LFSR_SEED == 8'h00) begin : g_bad_cfg
        $error("keypad_emulator: GAP_CYCLES/BOUNCE_CYCLES must be >=1 and LFSR_SEED nonzero");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hold_q, hold_last;
    logic [7:0]       rc_q;
    logic             key_closed, closed_nxt;
    logic             accept;

    assign accept    = (state == IDLE) && req.req_valid;
    assign hold_last = (hold_q == '0) ? '0 : hold_q - CNT_W'(1);

`ifdef KEYPAD_BOUNCE_EN
    localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    logic chatter;

    chatter_lfsr #(.SEED(LFSR_SEED)) u_chatter (
        .clk     (clk),
        .reset   (reset),
        .en      ((state == PRESS) || (state == RELEASE)),
        .chatter (chatter)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            key_closed <= 1'b0;
            rc_q       <= '0;
            hold_q     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            key_closed <= closed_nxt;
            if (accept) begin
                rc_q   <= key_to_rowcol(req.req_key);
                hold_q <= req.req_hold;
            end
        end
    end

    // Next state; the shared counter reloads to zero on every state change
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CNT_W'(1);
        closed_nxt = key_closed;
        case (state)
            IDLE: begin
                cnt_nxt    = '0;
                closed_nxt = 1'b0;
                if (accept) state_nxt = PRESS;
            end
            PRESS: begin
`ifdef KEYPAD_BOUNCE_EN
                closed_nxt = chatter;
                if (cnt == EDGE_LAST) begin
                    state_nxt  = HOLD;
                    cnt_nxt    = '0;
                    closed_nxt = 1'b1;
                end
`else
                state_nxt  = HOLD;
                cnt_nxt    = '0;
                closed_nxt = 1'b1;
`endif
            end
            HOLD: begin
                closed_nxt = 1'b1;
                if (cnt == hold_last) begin
                    state_nxt  = RELEASE;
                    cnt_nxt    = '0;
                    closed_nxt = 1'b0;
                end
            end
            RELEASE: begin
`ifdef KEYPAD_BOUNCE_EN
                closed_nxt = chatter;
                if (cnt == EDGE_LAST) begin
                    state_nxt  = GAP;
                    cnt_nxt    = '0;
                    closed_nxt = 1'b0;
                end
`else
                state_nxt  = GAP;
                cnt_nxt    = '0;
                closed_nxt = 1'b0;
`endif
            end
            GAP: begin
                closed_nxt = 1'b0;
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                cnt_nxt    = '0;
                closed_nxt = 1'b0;
            end
        endcase
    end

    // Passive switch: column drive passes straight through to the key's row
    assign row           = ((|(col & rc_q[3:0])) && key_closed) ? rc_q[7:4] : 4'b0000;
    assign busy          = (state != IDLE);
    assign req.req_ready = (state == IDLE);
    assign done          = (state == GAP) && (cnt == GAP_LAST);

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench for keypad_emulator against a per-cycle phase model.
module tb_keypad_emulator;

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned GAP    = 20;
    localparam int unsigned BOUNCE = 5;
`ifdef KEYPAD_BOUNCE_EN
    localparam int EDGE = BOUNCE;
    localparam bit BOUNCY = 1'b1;
`else
    localparam int EDGE = 1;
    localparam bit BOUNCY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       done;

    keypad_if #(.CNT_W(CNT_W)) bus ();

    keypad_emulator #(
        .CNT_W         (CNT_W),
        .GAP_CYCLES    (GAP),
        .BOUNCE_CYCLES (BOUNCE),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (bus),
        .col   (col),
        .row   (row),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Physical keypad layout, row-major from the top-left corner
    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] exp_row(input logic [3:0] key, input logic [3:0] c, input bit closed);
        logic [3:0] r = 4'b0000;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (keymap[ri*4+ci] == key && closed && c[ci]) r = 4'(1 << ri);
        return r;
    endfunction

    // One transaction: the accept cycle, PRESS, HOLD, RELEASE and GAP, each cycle checked.
    // mode 0: constant col, 1: rotating one-hot, 2: random. abort_at asserts reset at that cycle.
    task automatic press(input logic [3:0] key, input logic [CNT_W-1:0] hold, input int mode,
                         input logic [3:0] col_const, input bit keep_valid,
                         input logic [3:0] next_key, input int abort_at);
        int  h     = (hold == 0) ? 1 : int'(hold);
        int  total = 1 + 2*EDGE + h + GAP;
        bit  closed, dc;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.req_valid = 1'b1;
                bus.req_key   = key;
                bus.req_hold  = hold;
            end else if (i == 1) begin
                bus.req_valid = keep_valid;
                bus.req_key   = next_key;
                bus.req_hold  = CNT_W'($urandom_range(0, 30));
            end
            if (i == abort_at) begin
                reset = 1'b1;
                return;
            end
            case (mode)
                0:       col = col_const;
                1:       col = 4'(1 << (i % 4));
                default: col = 4'($urandom);
            endcase
            closed = (i >= 1 + EDGE) && (i < 1 + EDGE + h);
            dc     = BOUNCY && (((i >= 1) && (i < 1 + EDGE)) ||
                                ((i >= 1 + EDGE + h) && (i < 1 + 2*EDGE + h)));
            #1;
            if (!dc) check("row", 32'(row), 32'(exp_row(key, col, closed)));
            check("busy",  32'(busy),          32'(i != 0));
            check("ready", 32'(bus.req_ready), 32'(i == 0));
            check("done",  32'(done),          32'(i == total - 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        col           = 4'b1111;
        bus.req_valid = 1'b0;
        bus.req_key   = 4'h0;
        bus.req_hold  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_row",   32'(row),           32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done",  32'(done),          32'd0);
        reset = 1'b0;

        // Reset in the middle of HOLD discards the press without a done pulse
        press(4'h5, 24'd10, 0, 4'b0010, 1'b0, 4'h0, 1 + EDGE + 3);
        @(posedge clk);
        #1;
        check("abort_row",   32'(row),           32'd0);
        check("abort_busy",  32'(busy),          32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_done",  32'(done),          32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_busy", 32'(busy), 32'd0);
        end

        press(4'h5, 24'd10, 0, 4'b0010, 1'b0, 4'h0, -1);
        press(4'hD, 24'd50, 1, 4'b0000, 1'b0, 4'h0, -1);
        // Held request for key F must wait until the key 1 transaction has fully finished
        press(4'h1, 24'd8, 2, 4'b0000, 1'b1, 4'hF, -1);
        press(4'hF, 24'd5, 2, 4'b0000, 1'b0, 4'h0, -1);
        press(4'h0, 24'd0, 0, 4'b1111, 1'b0, 4'h0, -1);
        press(4'hA, 24'd100, 0, 4'b1000, 1'b0, 4'h0, -1);

        for (int t = 0; t < 10; t++)
            press(4'($urandom), CNT_W'($urandom_range(0, 25)), int'($urandom_range(0, 2)),
                  4'($urandom), 1'b0, 4'h0, -1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            col = 4'b1111;
            #1;
            check("idle_row",   32'(row),           32'd0);
            check("idle_ready", 32'(bus.req_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
